// File: rtl/lcd_spi_serializer.sv
// lcd_spi_serializer: byte-wide SPI transmitter for the PCD8544 (Nokia 5110) LCD.
// Shifts one byte MSB-first on mosi/sclk with sce framing and dc steering, and
// produces the LCD hardware reset pulse after system reset.
// Optional feature macro: SPI_CS_HOLD_EN keeps sce low across back-to-back
// bytes and raises it only on entry to IDLE.
//
// Handshake: start is a level request. Each byte is sampled on the edge that
// enters LOAD (data_in, command, div_factor); avail pulses for one clock in
// DONE when the byte is finished. With start still high after GAP the next
// byte is loaded, so a producer updates its inputs within GAP_CYCLES of avail.
module lcd_spi_serializer #(
    parameter int RST_CYCLES = 50,
    parameter int GAP_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [7:0]  data_in_i,
    input  logic        start_i,
    input  logic [15:0] div_factor_i,
    input  logic        command_i,
    output logic        mosi_o,
    output logic        sclk_o,
    output logic        sce_o,
    output logic        busy_o,
    output logic        avail_o,
    output logic        dc_o,
    output logic        rst_o,
    output logic [2:0]  state_o
);

    typedef enum logic [2:0] {
        S_LCDRST = 3'd0,
        S_IDLE   = 3'd1,
        S_LOAD   = 3'd2,
        S_SHIFT  = 3'd3,
        S_DONE   = 3'd4,
        S_GAP    = 3'd5
    } state_t;

    localparam logic [15:0] RST_LOAD = 16'(RST_CYCLES - 1);
    localparam logic [15:0] GAP_LOAD = 16'(GAP_CYCLES - 1);

`ifdef SPI_CS_HOLD_EN
    // Chip enable stays asserted between bytes; IDLE entry releases it.
    localparam logic SCE_AFTER_BYTE = 1'b0;
`else
    // Chip enable is released at the end of every byte.
    localparam logic SCE_AFTER_BYTE = 1'b1;
`endif

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;      // shared down-counter: reset pulse, half-period, gap
    logic [15:0] div_q, div_d;      // latched half-period, never zero
    logic [7:0]  shift_q, shift_d;  // byte in flight
    logic [2:0]  bit_q, bit_d;      // index of the bit currently on mosi
    logic        mosi_q, mosi_d;
    logic        sclk_q, sclk_d;
    logic        sce_q, sce_d;
    logic        busy_q, busy_d;
    logic        avail_q, avail_d;
    logic        dc_q, dc_d;
    logic        rst_q, rst_d;
    logic        do_load;

    // Next-state and registered-output logic; outputs are computed for the state being entered.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        mosi_d  = mosi_q;
        sclk_d  = sclk_q;
        sce_d   = sce_q;
        busy_d  = busy_q;
        avail_d = 1'b0;
        dc_d    = dc_q;
        rst_d   = rst_q;
        do_load = 1'b0;

        case (state_q)
            S_LCDRST: begin
                if (cnt_q == 16'd0) begin
                    state_d = S_IDLE;
                    rst_d   = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_IDLE: begin
                if (start_i) begin
                    do_load = 1'b1;
                end
            end
            S_LOAD: begin
                state_d = S_SHIFT;
                cnt_d   = div_q - 16'd1;
            end
            S_SHIFT: begin
                if (cnt_q != 16'd0) begin
                    cnt_d = cnt_q - 16'd1;
                end else if (!sclk_q) begin
                    // Low half finished: rising edge, mosi held.
                    sclk_d = 1'b1;
                    cnt_d  = div_q - 16'd1;
                end else if (bit_q == 3'd0) begin
                    // High half of the last bit finished.
                    state_d = S_DONE;
                    sclk_d  = 1'b0;
                    mosi_d  = 1'b0;
                    avail_d = 1'b1;
                    sce_d   = SCE_AFTER_BYTE;
                end else begin
                    // Falling edge: next bit goes out on the same edge.
                    sclk_d = 1'b0;
                    bit_d  = bit_q - 3'd1;
                    mosi_d = shift_q[bit_q - 3'd1];
                    cnt_d  = div_q - 16'd1;
                end
            end
            S_DONE: begin
                state_d = S_GAP;
                cnt_d   = GAP_LOAD;
            end
            S_GAP: begin
                if (cnt_q == 16'd0) begin
                    if (start_i) begin
                        do_load = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        sce_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                state_d = S_LCDRST;
                cnt_d   = RST_LOAD;
                rst_d   = 1'b0;
                busy_d  = 1'b1;
                sce_d   = 1'b1;
            end
        endcase

        // Byte load shared by IDLE and the end of GAP.
        if (do_load) begin
            state_d = S_LOAD;
            shift_d = data_in_i;
            dc_d    = command_i;
            div_d   = (div_factor_i == 16'd0) ? 16'd1 : div_factor_i;
            bit_d   = 3'd7;
            sce_d   = 1'b0;
            mosi_d  = data_in_i[7];
            sclk_d  = 1'b0;
            busy_d  = 1'b1;
        end
    end

    // State and output registers with synchronous reset to the LCD-reset state.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_LCDRST;
            cnt_q   <= RST_LOAD;
            div_q   <= 16'd1;
            shift_q <= 8'd0;
            bit_q   <= 3'd0;
            mosi_q  <= 1'b0;
            sclk_q  <= 1'b0;
            sce_q   <= 1'b1;
            busy_q  <= 1'b1;
            avail_q <= 1'b0;
            dc_q    <= 1'b0;
            rst_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            mosi_q  <= mosi_d;
            sclk_q  <= sclk_d;
            sce_q   <= sce_d;
            busy_q  <= busy_d;
            avail_q <= avail_d;
            dc_q    <= dc_d;
            rst_q   <= rst_d;
        end
    end

    assign mosi_o  = mosi_q;
    assign sclk_o  = sclk_q;
    assign sce_o   = sce_q;
    assign busy_o  = busy_q;
    assign avail_o = avail_q;
    assign dc_o    = dc_q;
    assign rst_o   = rst_q;
    assign state_o = state_q;

endmodule
